// File: rtl/clk_div_bank_pkg.sv
// Shared constants for the game-speed clock divider bank and the level mux
// that selects one of its outputs.
package clk_div_bank_pkg;

    // Counter width and default half-periods for a 50 MHz board clock.
    localparam int CNT_W = 26;
    localparam int HALF1 = 25_000_000;  // 1 Hz
    localparam int HALF2 = 12_500_000;  // 2 Hz
    localparam int HALF3 = 6_250_000;   // 4 Hz
    localparam int HALF4 = 3_125_000;   // 8 Hz

    // Level select encoding used by the downstream 4:1 mux.
    localparam int LEVEL_W = 2;

    typedef enum logic [LEVEL_W-1:0] {
        LEVEL_1HZ = 2'd0,
        LEVEL_2HZ = 2'd1,
        LEVEL_4HZ = 2'd2,
        LEVEL_8HZ = 2'd3
    } level_e;

endpackage

// File: rtl/clk_div_bank_half_period_divider.sv
// One divider channel: a registered 50% square wave whose level flips every
// HALF enabled cycles, plus a one-cycle tick on each 0->1 transition.
module half_period_divider #(
    parameter int CNT_W = 26,
    parameter int HALF  = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic wave,
    output logic tick
);

    // Terminal count: the counter runs 0..HALF-1 and never beyond.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;
    logic             tick_q, tick_d;

    // Next state: restart beats enable; a disabled cycle holds phase but drops the tick.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        tick_d = 1'b0;
        if (restart) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
                tick_d = ~wave_q;   // only when the wave is about to go high
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
            tick_q <= tick_d;
        end
    end

    assign wave = wave_q;
    assign tick = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of four independent half-period dividers producing the game-speed
// square waves cl1..cl4 and their rising-edge ticks. All outputs are flops
// in the board-clock domain and are meant to be used as data or enables.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int CNT_W = clk_div_bank_pkg::CNT_W,
    parameter int HALF1 = clk_div_bank_pkg::HALF1,
    parameter int HALF2 = clk_div_bank_pkg::HALF2,
    parameter int HALF3 = clk_div_bank_pkg::HALF3,
    parameter int HALF4 = clk_div_bank_pkg::HALF4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic cl1,
    output logic cl2,
    output logic cl3,
    output logic cl4,
    output logic tick1,
    output logic tick2,
    output logic tick3,
    output logic tick4
);

    half_period_divider #(.CNT_W(CNT_W), .HALF(HALF1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .wave(cl1), .tick(tick1)
    );

    half_period_divider #(.CNT_W(CNT_W), .HALF(HALF2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .wave(cl2), .tick(tick2)
    );

    half_period_divider #(.CNT_W(CNT_W), .HALF(HALF3)) u_div3 (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .wave(cl3), .tick(tick3)
    );

    half_period_divider #(.CNT_W(CNT_W), .HALF(HALF4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .wave(cl4), .tick(tick4)
    );

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Generates the four game-speed clock signals cl1..cl4 from the single board clock.
- Feeds directly into the level selector 4:1 mux, which picks one of them as clkhz.
- All outputs are registered square waves in the board-clock domain. They are not derived clocks, and downstream logic samples them as data or enables.
- Also emits a one-cycle rising-edge tick per channel, so consumers need no edge detector.

Parameters:
- CNT_W, 26: counter width; every HALFn must satisfy 1 <= HALFn <= 2^CNT_W - 1.
- HALF1, 25_000_000: half-period of cl1 in clk cycles (1 Hz at 50 MHz).
- HALF2, 12_500_000: half-period of cl2 (2 Hz).
- HALF3, 6_250_000: half-period of cl3 (4 Hz).
- HALF4, 3_125_000: half-period of cl4 (8 Hz).

Ports:
- clk  input  1  board clock, 50 MHz nominal.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; low freezes all channels.
- restart  input  1  synchronous clear of all channels, used on level change to re-phase.
- cl1  output  1  square wave, period 2*HALF1 enabled cycles.
- cl2  output  1  square wave, period 2*HALF2.
- cl3  output  1  square wave, period 2*HALF3.
- cl4  output  1  square wave, period 2*HALF4.
- tick1  output  1  1-cycle pulse coincident with the first cycle cl1 is high.
- tick2  output  1  same for cl2.
- tick3  output  1  same for cl3.
- tick4  output  1  same for cl4.

Behaviour:
- Reset (rst_n=0, asynchronous, any time): all counters 0; cl1..cl4 = 0; tick1..tick4 = 0. Outputs hold these values until the first clk edge with rst_n=1.
- Per channel n, priority order at each rising clk edge:
  1. restart=1: cnt_n <= 0, cl_n <= 0, tick_n <= 0. Overrides en.
  2. en=0: cnt_n and cl_n hold; tick_n <= 0.
  3. en=1, cnt_n != HALFn-1: cnt_n <= cnt_n+1; tick_n <= 0.
  4. en=1, cnt_n == HALFn-1: cnt_n <= 0; cl_n <= ~cl_n; tick_n <= ~cl_n, i.e. high only on the 0->1 transition.
- Timing: cl_n first rises on the HALFn-th enabled edge after reset or restart. Period is exactly 2*HALFn enabled cycles; duty is exactly 50%.
- tick_n is high for exactly one clk cycle per cl_n period, in the same cycle cl_n first reads 1. A tick is never asserted while en=0 or restart=1.
- HALFn = 1: cl_n toggles on every enabled edge; tick_n is high on every second enabled edge.
- Counter wrap: cnt_n never exceeds HALFn-1. No free-running overflow.
- en toggling mid-period: phase is preserved. The period stretches by the number of disabled cycles.
- restart asserted while cl_n=1: cl_n drops to 0 on that edge, and no tick is produced.
- Channels are independent. Equal HALF values yield identical, phase-aligned outputs.
- Latency: zero combinational paths from inputs to outputs; every output is a flop.

Decomposition:
- Shared include file of localparams: CNT_W and default HALF1..HALF4 for 50 MHz. The same file holds the LEVEL_W=2 encoding that the level mux uses.
- One natural sub-module, half_period_divider: params CNT_W and HALF; ports clk, rst_n, en, restart, wave, tick.
- clk_div_bank instantiates half_period_divider four times.

Test Plan:
Benches override HALF1=2, HALF2=3, HALF3=5, HALF4=1, CNT_W=4.
- Reset then en=1 for 20 cycles -> cl1 rises at edge 2 with period 4; cl2 rises at edge 3 with period 6; cl3 rises at edge 5 with period 10; cl4 toggles every edge. Each tick is a 1-cycle pulse aligned with its rising edge.
- en low for 3 cycles mid-period of cl2 (cnt=1, cl2=1) -> cl2 and the counter hold; ticks stay 0; the next cl2 toggle is delayed by exactly 3 cycles.
- restart pulsed while cl3=1, cnt3=2 -> next edge: cl3=0, all counters 0, no tick; cl3 re-rises 5 enabled edges later.
- restart and en both high for 4 cycles -> all cl and tick stay 0 (restart has priority).
- rst_n asserted asynchronously between clk edges while cl1=1 -> cl1 and tick1 go to 0 immediately, without waiting for a clk edge; sequence after release matches the first scenario.
- Over 40 enabled cycles -> the tick1 count equals 10, and cl1 high-cycle count equals low-cycle count (20/20).
